// File: rtl/ram_dma_pkg.sv
// Shared types and defaults for the RAM block-transfer engine.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package ram_dma_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 16;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_FILL = 3'd4,
    ST_FIN  = 3'd5
  } state_t;

  // States in which the engine holds (or is asking for) the RAM bus.
  function automatic logic owns_bus(input state_t s);
    return (s == ST_REQ) || (s == ST_RD) || (s == ST_WR) || (s == ST_FILL);
  endfunction

  // States that perform a RAM access when the grant is present.
  function automatic logic is_access(input state_t s);
    return (s == ST_RD) || (s == ST_WR) || (s == ST_FILL);
  endfunction

endpackage

// File: rtl/ram_dma_ctr.sv
// Source/destination pointers (modulo 2^ADDR_W) and remaining-word counter.
// Latency: next-value outputs are combinational, state updates on the clock edge.
// Backpressure: pointers and count hold whenever no step is requested.
module ram_dma_ctr
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_src,
  input  logic [ADDR_W-1:0] i_dst,
  input  logic [ADDR_W-1:0] i_len,
  input  logic              i_step,      // one word written: dst+1, count-1
  input  logic              i_step_src,  // one copy word done: src+1
  output logic [ADDR_W-1:0] o_src_nxt,
  output logic [ADDR_W-1:0] o_dst_nxt,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_rem;
  logic [ADDR_W-1:0] w_rem_nxt;

  // Next pointer/count values; the top uses the pointer values to preload the address register.
  always_comb begin
    o_src_nxt = r_src;
    o_dst_nxt = r_dst;
    w_rem_nxt = r_rem;
    if (i_load) begin
      o_src_nxt = i_src;
      o_dst_nxt = i_dst;
      w_rem_nxt = i_len;
    end else begin
      if (i_step_src) o_src_nxt = r_src + ADDR_W'(1);
      if (i_step) begin
        o_dst_nxt = r_dst + ADDR_W'(1);
        w_rem_nxt = r_rem - ADDR_W'(1);
      end
    end
  end

  // Pointer and count registers; natural overflow gives the 0x1FF -> 0x000 wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_src <= '0;
      r_dst <= '0;
      r_rem <= '0;
    end else begin
      r_src <= o_src_nxt;
      r_dst <= o_dst_nxt;
      r_rem <= w_rem_nxt;
    end
  end

  assign o_last = (r_rem == ADDR_W'(1));

endmodule

// File: rtl/ram_dma.sv
// Block copy / fill engine driving the on-chip RAM port; fill mode built only with RAM_DMA_FILL_EN.
// Latency: REQ one cycle after start, copy done 2N+2 cycles after the start cycle, fill N+2, len 0 in 1.
// Backpressure: bus_gnt sampled each edge; without it the next access cycle is idle (CS low) and held.
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic              bus_req,
  input  logic              bus_gnt,
  output logic [ADDR_W-1:0] AddrRAM,
  output logic [DATA_W-1:0] DinRAM,
  input  logic [DATA_W-1:0] DoutRAM,
  output logic              write,
  output logic              CS
);

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_busy;
  logic              r_done;
  logic              r_cs;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_hold;

  logic              w_accept;
  logic              w_step;
  logic              w_step_src;
  logic              w_capture;
  logic              w_last;
  logic [ADDR_W-1:0] w_src_nxt;
  logic [ADDR_W-1:0] w_dst_nxt;

  logic              w_acc_nxt;
  logic              w_cs_nxt;
  logic              w_write_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_din_nxt;

  // A command is only taken while idle; strobes during a transfer are dropped.
  assign w_accept = (r_state == ST_IDLE) && start;

`ifdef RAM_DMA_FILL_EN
  logic              r_mode;
  logic [DATA_W-1:0] r_fill_val;
  logic              w_is_fill;

  // Latch the fill-mode command fields at acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mode     <= MODE_COPY;
      r_fill_val <= '0;
    end else if (w_accept) begin
      r_mode     <= mode;
      r_fill_val <= fill_val;
    end
  end

  assign w_is_fill = (r_mode == MODE_FILL);
`else
  // Without fill support every command is a copy; mode and fill_val are ignored.
  logic w_unused_cfg;
  assign w_unused_cfg = ^{mode, fill_val, MODE_COPY, MODE_FILL};
`endif

  ram_dma_ctr #(
    .ADDR_W (ADDR_W)
  ) u_ctr (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_load     (w_accept),
    .i_src      (src),
    .i_dst      (dst),
    .i_len      (len),
    .i_step     (w_step),
    .i_step_src (w_step_src),
    .o_src_nxt  (w_src_nxt),
    .o_dst_nxt  (w_dst_nxt),
    .o_last     (w_last)
  );

  // Next-state logic; an access state only advances after a cycle in which CS was really driven.
  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_step_src  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = (len == '0) ? ST_FIN : ST_REQ;
      end
      ST_REQ: begin
        if (bus_gnt) begin
`ifdef RAM_DMA_FILL_EN
          w_state_nxt = w_is_fill ? ST_FILL : ST_RD;
`else
          w_state_nxt = ST_RD;
`endif
        end
      end
      ST_RD: begin
        if (r_cs) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_WR;
        end
      end
      ST_WR: begin
        if (r_cs) begin
          w_step      = 1'b1;
          w_step_src  = 1'b1;
          w_state_nxt = w_last ? ST_FIN : ST_RD;
        end
      end
`ifdef RAM_DMA_FILL_EN
      ST_FILL: begin
        if (r_cs) begin
          w_step      = 1'b1;
          w_state_nxt = w_last ? ST_FIN : ST_FILL;
        end
      end
`endif
      ST_FIN: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the RAM port is fully registered.
  always_comb begin
    w_acc_nxt   = is_access(w_state_nxt);
    w_cs_nxt    = w_acc_nxt && bus_gnt;
    w_write_nxt = w_cs_nxt && (w_state_nxt != ST_RD);
    w_addr_nxt  = r_addr;
    w_din_nxt   = r_din;
    if (w_acc_nxt) w_addr_nxt = (w_state_nxt == ST_RD) ? w_src_nxt : w_dst_nxt;
    if (w_state_nxt == ST_WR) w_din_nxt = w_capture ? DoutRAM : r_hold;
`ifdef RAM_DMA_FILL_EN
    if (w_state_nxt == ST_FILL) w_din_nxt = r_fill_val;
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Registered Moore outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs    <= 1'b0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_din   <= '0;
    end else begin
      r_busy  <= owns_bus(w_state_nxt);
      r_done  <= (w_state_nxt == ST_FIN);
      r_cs    <= w_cs_nxt;
      r_write <= w_write_nxt;
      r_addr  <= w_addr_nxt;
      r_din   <= w_din_nxt;
    end
  end

  // Data holding register: the word read in RD, kept for a WR that has to wait for the grant.
  always_ff @(posedge clk) begin
    if (!rst_n)         r_hold <= '0;
    else if (w_capture) r_hold <= DoutRAM;
  end

  // busy and bus_req cover the same states (REQ through the last access).
  assign busy    = r_busy;
  assign bus_req = r_busy;
  assign done    = r_done;
  assign CS      = r_cs;
  assign write   = r_write;
  assign AddrRAM = r_addr;
  assign DinRAM  = r_din;

endmodule

// File: tb/tb_ram_dma.sv
// Directed bench for ram_dma with a behavioural 512x16 RAM on the engine's port.
// Cycle 0 is the cycle in which start is high; cycle k follows the k-th clock edge after it.
// Fill checks are built when RAM_DMA_FILL_EN is defined, otherwise mode=1 must behave as a copy.
module tb_ram_dma;

  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW-1:0] len;
  logic [DW-1:0] fill_val;
  logic          bus_gnt;
  wire           busy;
  wire           done;
  wire           bus_req;
  wire  [AW-1:0] AddrRAM;
  wire  [DW-1:0] DinRAM;
  logic [DW-1:0] DoutRAM;
  wire           write;
  wire           CS;

  always #5 clk = ~clk;

  ram_dma #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src(src), .dst(dst),
    .len(len), .fill_val(fill_val), .busy(busy), .done(done), .bus_req(bus_req),
    .bus_gnt(bus_gnt), .AddrRAM(AddrRAM), .DinRAM(DinRAM), .DoutRAM(DoutRAM),
    .write(write), .CS(CS)
  );

  // RAM model: combinational read, write on the clock edge; preload port for setup.
  logic [DW-1:0] mem [0:511];
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_dat = '0;

  assign DoutRAM = mem[AddrRAM];

  always @(posedge clk) begin
    if (CS && write) mem[AddrRAM] <= DinRAM;
    else if (pl_we)  mem[pl_addr] <= pl_dat;
  end

  int checks = 0;
  int errors = 0;

  int done_cyc;
  int cnt_wr;
  int cnt_cs;
  int cnt_busy;
  int cnt_req;
  logic [AW-1:0] rd_q[$];
  logic [AW-1:0] wr_q[$];
  logic cs_hist [0:255];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
    pl_addr = a;
    pl_dat  = v;
    pl_we   = 1'b1;
    tick();
    pl_we   = 1'b0;
  endtask

  // Issue one command and watch the port until done (bounded); optional grant gap and stray start.
  task automatic run_cmd(input logic m, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW-1:0] l, input logic [DW-1:0] fv,
                         input int drop_at, input int drop_len, input int poke_at);
    mode = m; src = s; dst = d; len = l; fill_val = fv; bus_gnt = 1'b1; start = 1'b1;
    done_cyc = -1; cnt_wr = 0; cnt_cs = 0; cnt_busy = 0; cnt_req = 0;
    rd_q.delete();
    wr_q.delete();
    for (int i = 0; i < 256; i++) cs_hist[i] = 1'b0;
    for (int c = 1; c < 256 && done_cyc < 0; c++) begin
      tick();
      start = 1'b0;
      if (c == poke_at) begin
        start = 1'b1; src = 9'h1A0; dst = 9'h1C0; len = 9'd7;
      end
      bus_gnt = !((c >= drop_at) && (c < drop_at + drop_len));
      cs_hist[c] = CS;
      if (CS) begin
        cnt_cs++;
        if (write) begin cnt_wr++; wr_q.push_back(AddrRAM); end
        else       rd_q.push_back(AddrRAM);
      end
      if (busy)    cnt_busy++;
      if (bus_req) cnt_req++;
      if (done)    done_cyc = c;
    end
    tick();
    start   = 1'b0;
    bus_gnt = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0;
    fill_val = '0; bus_gnt = 1'b1;
    for (int i = 0; i < 512; i++) begin
      tick();
      if (i < 3) begin
        checks++; if (i == 2 && busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      end
    end
    checks++; if (done    !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL reset_bus_req: got %b expected 0", bus_req); end
    checks++; if (CS      !== 1'b0) begin errors++; $display("FAIL reset_cs: got %b expected 0", CS); end
    checks++; if (write   !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", write); end
    checks++; if (AddrRAM !== 9'h000) begin errors++; $display("FAIL reset_addr: got %h expected 000", AddrRAM); end
    checks++; if (DinRAM  !== 16'h0000) begin errors++; $display("FAIL reset_din: got %h expected 0000", DinRAM); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_copy();
    logic [DW-1:0] v [4];
    v[0] = 16'h00A1; v[1] = 16'h00B2; v[2] = 16'h00C3; v[3] = 16'h00D4;
    for (int i = 0; i < 4; i++) begin poke(AW'(9'h010 + i), v[i]); poke(AW'(9'h100 + i), 16'h0000); end
    poke(9'h104, 16'h5555);
    run_cmd(1'b0, 9'h010, 9'h100, 9'd4, 16'h0000, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[9'h100 + i] !== v[i]) begin errors++; $display("FAIL copy_data[%0d]: got %h expected %h", i, mem[9'h100 + i], v[i]); end
    end
    checks++; if (mem[9'h104] !== 16'h5555) begin errors++; $display("FAIL copy_past_end: got %h expected 5555", mem[9'h104]); end
    // 2N+3 cycles counting the start cycle through the done cycle
    checks++; if (done_cyc + 1 !== 11) begin errors++; $display("FAIL copy_latency: got %0d expected 11", done_cyc + 1); end
    checks++; if (cnt_wr !== 4) begin errors++; $display("FAIL copy_writes: got %0d expected 4", cnt_wr); end
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL copy_idle_after: done %b busy %b expected 0 0", done, busy); end
  endtask

`ifdef RAM_DMA_FILL_EN
  task automatic test_fill();
    for (int i = 0; i < 4; i++) poke(AW'(9'h020 + i), 16'h1111);
    run_cmd(1'b1, 9'h000, 9'h020, 9'd3, 16'hBEEF, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[9'h020 + i] !== 16'hBEEF) begin errors++; $display("FAIL fill_data[%0d]: got %h expected BEEF", i, mem[9'h020 + i]); end
    end
    checks++; if (mem[9'h023] !== 16'h1111) begin errors++; $display("FAIL fill_past_end: got %h expected 1111", mem[9'h023]); end
    checks++; if (done_cyc + 1 !== 6) begin errors++; $display("FAIL fill_latency: got %0d expected 6", done_cyc + 1); end
    checks++; if (cnt_cs !== 3 || cnt_wr !== 3) begin errors++; $display("FAIL fill_accesses: cs %0d wr %0d expected 3 3", cnt_cs, cnt_wr); end
  endtask
`else
  task automatic test_fill();
    for (int i = 0; i < 3; i++) poke(AW'(9'h030 + i), DW'(16'h3000 + i));
    for (int i = 0; i < 4; i++) poke(AW'(9'h020 + i), 16'h1111);
    run_cmd(1'b1, 9'h030, 9'h020, 9'd3, 16'hBEEF, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[9'h020 + i] !== DW'(16'h3000 + i)) begin errors++; $display("FAIL nofill_data[%0d]: got %h expected %h", i, mem[9'h020 + i], DW'(16'h3000 + i)); end
    end
    checks++; if (mem[9'h023] !== 16'h1111) begin errors++; $display("FAIL nofill_past_end: got %h expected 1111", mem[9'h023]); end
    checks++; if (done_cyc + 1 !== 9) begin errors++; $display("FAIL nofill_latency: got %0d expected 9", done_cyc + 1); end
    checks++; if (cnt_cs !== 6 || cnt_wr !== 3) begin errors++; $display("FAIL nofill_accesses: cs %0d wr %0d expected 6 3", cnt_cs, cnt_wr); end
  endtask
`endif

  task automatic test_wrap();
    logic [AW-1:0] ra [4];
    ra[0] = 9'h1FE; ra[1] = 9'h1FF; ra[2] = 9'h000; ra[3] = 9'h001;
    for (int i = 0; i < 4; i++) poke(ra[i], DW'(16'h7001 + i));
    run_cmd(1'b0, 9'h1FE, 9'h0F0, 9'd4, 16'h0000, 0, 0, 0);
    checks++; if (rd_q.size() !== 4 || wr_q.size() !== 4) begin errors++; $display("FAIL wrap_counts: rd %0d wr %0d expected 4 4", rd_q.size(), wr_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_q[i] !== ra[i]) begin errors++; $display("FAIL wrap_rd_addr[%0d]: got %h expected %h", i, rd_q[i], ra[i]); end
      checks++; if (wr_q[i] !== AW'(9'h0F0 + i)) begin errors++; $display("FAIL wrap_wr_addr[%0d]: got %h expected %h", i, wr_q[i], AW'(9'h0F0 + i)); end
      checks++; if (mem[9'h0F0 + i] !== DW'(16'h7001 + i)) begin errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, mem[9'h0F0 + i], DW'(16'h7001 + i)); end
    end
  endtask

  task automatic test_len0();
    run_cmd(1'b0, 9'h010, 9'h1F0, 9'd0, 16'h0000, 0, 0, 0);
    checks++; if (done_cyc !== 1) begin errors++; $display("FAIL len0_done_cycle: got %0d expected 1", done_cyc); end
    checks++; if (cnt_cs !== 0) begin errors++; $display("FAIL len0_cs: got %0d expected 0", cnt_cs); end
    checks++; if (cnt_busy !== 0 || cnt_req !== 0) begin errors++; $display("FAIL len0_busy_req: busy %0d req %0d expected 0 0", cnt_busy, cnt_req); end
  endtask

  task automatic test_busy_ignore();
    for (int i = 0; i < 3; i++) poke(AW'(9'h050 + i), DW'(16'h0501 + i));
    poke(9'h1C0, 16'h1234);
    run_cmd(1'b0, 9'h050, 9'h150, 9'd3, 16'h0000, 0, 0, 3);
    for (int i = 0; i < 3; i++) begin
      checks++; if (mem[9'h150 + i] !== DW'(16'h0501 + i)) begin errors++; $display("FAIL ignore_data[%0d]: got %h expected %h", i, mem[9'h150 + i], DW'(16'h0501 + i)); end
    end
    checks++; if (mem[9'h1C0] !== 16'h1234) begin errors++; $display("FAIL ignore_stray_dst: got %h expected 1234", mem[9'h1C0]); end
    checks++; if (done_cyc + 1 !== 9 || cnt_wr !== 3) begin errors++; $display("FAIL ignore_timing: latency %0d wr %0d expected 9 3", done_cyc + 1, cnt_wr); end
  endtask

  task automatic test_grant_drop();
    for (int i = 0; i < 4; i++) poke(AW'(9'h040 + i), DW'(16'h4000 + i));
    // grant absent at the edges ending cycles 4..6 removes the second WR slot (cycle 5) and two more
    run_cmd(1'b0, 9'h040, 9'h140, 9'd4, 16'h0000, 4, 3, 0);
    for (int i = 0; i < 4; i++) begin
      checks++; if (mem[9'h140 + i] !== DW'(16'h4000 + i)) begin errors++; $display("FAIL gnt_data[%0d]: got %h expected %h", i, mem[9'h140 + i], DW'(16'h4000 + i)); end
    end
    checks++; if (cs_hist[5] !== 1'b0 || cs_hist[6] !== 1'b0 || cs_hist[7] !== 1'b0) begin errors++; $display("FAIL gnt_cs_gap: got %b%b%b expected 000", cs_hist[5], cs_hist[6], cs_hist[7]); end
    checks++; if (cs_hist[4] !== 1'b1 || cs_hist[8] !== 1'b1) begin errors++; $display("FAIL gnt_cs_edges: got %b %b expected 1 1", cs_hist[4], cs_hist[8]); end
    checks++; if (done_cyc + 1 !== 14) begin errors++; $display("FAIL gnt_latency: got %0d expected 14", done_cyc + 1); end
    checks++; if (cnt_cs !== 8) begin errors++; $display("FAIL gnt_access_count: got %0d expected 8", cnt_cs); end
  endtask

  task automatic test_no_grant();
    int ncs;
    int got;
    ncs = 0; got = 0;
    mode = 1'b0; src = 9'h010; dst = 9'h180; len = 9'd1; bus_gnt = 1'b0; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      start = 1'b0;
      if (CS) ncs++;
    end
    checks++; if (bus_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL nognt_req: bus_req %b busy %b expected 1 1", bus_req, busy); end
    checks++; if (ncs !== 0) begin errors++; $display("FAIL nognt_cs: got %0d expected 0", ncs); end
    bus_gnt = 1'b1;
    for (int c = 0; c < 20 && got == 0; c++) begin
      tick();
      if (done) got = 1;
    end
    checks++; if (got !== 1) begin errors++; $display("FAIL nognt_done: got %0d expected 1", got); end
    checks++; if (mem[9'h180] !== 16'h00A1) begin errors++; $display("FAIL nognt_data: got %h expected 00A1", mem[9'h180]); end
    tick();
  endtask

  task automatic test_reset_mid();
    int nd;
    nd = 0;
    for (int i = 0; i < 8; i++) poke(AW'(9'h060 + i), DW'(16'h6000 + i));
    for (int i = 0; i < 3; i++) poke(AW'(9'h160 + i), 16'hFFFF);
    mode = 1'b0; src = 9'h060; dst = 9'h160; len = 9'd8; bus_gnt = 1'b1; start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      start = 1'b0;
    end
    // cycle 6 is the read of the third word
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (CS !== 1'b0 || write !== 1'b0) begin errors++; $display("FAIL rstmid_port: cs %b write %b expected 0 0", CS, write); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_status: busy %b done %b expected 0 0", busy, done); end
    for (int c = 0; c < 4; c++) begin
      tick();
      if (done) nd++;
    end
    checks++; if (nd !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d expected 0", nd); end
    checks++; if (mem[9'h160] !== 16'h6000 || mem[9'h161] !== 16'h6001) begin errors++; $display("FAIL rstmid_partial: got %h %h expected 6000 6001", mem[9'h160], mem[9'h161]); end
    checks++; if (mem[9'h162] !== 16'hFFFF) begin errors++; $display("FAIL rstmid_untouched: got %h expected FFFF", mem[9'h162]); end
    run_cmd(1'b0, 9'h060, 9'h170, 9'd2, 16'h0000, 0, 0, 0);
    checks++; if (done_cyc + 1 !== 7) begin errors++; $display("FAIL rstmid_fresh_latency: got %0d expected 7", done_cyc + 1); end
    checks++; if (mem[9'h170] !== 16'h6000 || mem[9'h171] !== 16'h6001) begin errors++; $display("FAIL rstmid_fresh_data: got %h %h expected 6000 6001", mem[9'h170], mem[9'h171]); end
  endtask

  initial begin
    test_reset();
    test_copy();
    test_fill();
    test_wrap();
    test_len0();
    test_busy_ignore();
    test_grant_drop();
    test_no_grant();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
